// File: rtl/pwm_capture.sv
// APB3 PWM capture peripheral: synchronizes pwm_in, measures high time and period
// in PCLK cycles, and reports them with sticky status, stuck-line detection and an irq.
module pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 250000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        pwm_in,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_WAIT_RISE = 2'd0,
    S_MEAS_HIGH = 2'd1,
    S_MEAS_LOW  = 2'd2,
    S_STUCK     = 2'd3
  } stateT;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             r_s1, r_s2, r_s3;
  logic             r_en, r_irqEn;
  logic             r_new, r_ovr;
  stateT            r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hiTmp;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_periodCap;
  logic [CNT_W-1:0] r_periodShadow;

  stateT            w_stateNext;
  logic             w_capture;
  logic             w_loadHi;
  logic             w_rise, w_fall;
  logic             w_timeout;
  logic             w_stuck;
  logic             w_wrEn, w_rdSetup;
  logic [1:0]       w_addr;
  logic [31:0]      w_rdData;
  logic             w_unused;

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign w_unused = &{1'b0, PADDR[31:4], PADDR[1:0], PWDATA[31:2]};

  assign w_addr    = PADDR[3:2];
  assign w_wrEn    = PSEL & PENABLE & PWRITE;
  assign w_rdSetup = PSEL & ~PENABLE & ~PWRITE;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_timeout = (r_cnt == TIMEOUT_VAL) & ~w_rise;
  assign w_stuck   = (r_state == S_STUCK);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state <= S_WAIT_RISE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A rise always wins over the timeout; the timeout in turn wins over a fall.
  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    w_loadHi    = 1'b0;
    if (!r_en) begin
      w_stateNext = S_WAIT_RISE;
    end else begin
      case (r_state)
        S_WAIT_RISE: begin
          if (w_rise) begin
            w_stateNext = S_MEAS_HIGH;
          end else if (w_timeout) begin
            w_stateNext = S_STUCK;
          end
        end
        S_MEAS_HIGH: begin
          if (w_timeout) begin
            w_stateNext = S_STUCK;
          end else if (w_fall) begin
            w_loadHi    = 1'b1;
            w_stateNext = S_MEAS_LOW;
          end
        end
        S_MEAS_LOW: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_stateNext = S_MEAS_HIGH;
          end else if (w_timeout) begin
            w_stateNext = S_STUCK;
          end
        end
        S_STUCK: begin
          if (w_rise) begin
            w_stateNext = S_MEAS_HIGH;
          end
        end
        default: begin
          w_stateNext = S_WAIT_RISE;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_cnt <= '0;
    end else if (!r_en) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_ONE;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_hiTmp     <= '0;
      r_high      <= '0;
      r_periodCap <= '0;
    end else begin
      if (w_loadHi) begin
        r_hiTmp <= r_cnt;
      end
      if (w_capture) begin
        r_high      <= r_hiTmp;
        r_periodCap <= r_cnt;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_en    <= 1'b0;
      r_irqEn <= 1'b0;
    end else if (w_wrEn && (w_addr == ADDR_CTRL)) begin
      r_en    <= PWDATA[0];
      r_irqEn <= PWDATA[1];
    end
  end

  // A capture in the same cycle as a W1C write keeps the flag set.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_new <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_capture) begin
        r_new <= 1'b1;
      end else if (w_wrEn && (w_addr == ADDR_STATUS) && PWDATA[0]) begin
        r_new <= 1'b0;
      end
      if (w_capture && r_new) begin
        r_ovr <= 1'b1;
      end else if (w_wrEn && (w_addr == ADDR_STATUS) && PWDATA[1]) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdData = 32'd0;
    case (w_addr)
      ADDR_CTRL:   w_rdData = {30'd0, r_irqEn, r_en};
      ADDR_HIGH:   w_rdData = 32'(r_high);
      ADDR_PERIOD: w_rdData = 32'(r_periodShadow);
      ADDR_STATUS: w_rdData = {28'd0, r_s3, w_stuck, r_ovr, r_new};
      default:     w_rdData = 32'd0;
    endcase
  end

  // Reading HIGH latches the matching period so a later PERIOD read stays paired.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      PRDATA         <= 32'd0;
      r_periodShadow <= '0;
    end else if (w_rdSetup) begin
      PRDATA <= w_rdData;
      if (w_addr == ADDR_HIGH) begin
        r_periodShadow <= r_periodCap;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq <= 1'b0;
    end else begin
      irq <= r_irqEn & (r_new | w_stuck);
    end
  end

endmodule
